rgb_led_fader: RTL
==================

Name: rgb_led_fader

Overview:
- Colour controller for the on-chip RGB LED driver.
- Accepts colour commands over a valid/ready handshake.
- Either jumps to the commanded colour or ramps each channel one LSB per fade tick toward it.
- Emits three glitch-free PWM signals that feed the driver's RGB PWM inputs directly. Driver current settings stay with the top level.

Parameters:
- PWM_BITS, 8, duty resolution per channel; PWM period = 2^PWM_BITS clocks.
- FADE_DIV, 1024, clocks per fade step; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_rgb  input  3*PWM_BITS  target colour {red, green, blue}
- cmd_fade  input  1  1 = ramp to target, 0 = jump to target
- busy  output  1  fade in progress
- cur_rgb  output  3*PWM_BITS  current colour {red, green, blue}
- pwm_red  output  1  red PWM
- pwm_green  output  1  green PWM
- pwm_blue  output  1  blue PWM

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous assert, active-low.
- Reset values: all registers 0, FSM IDLE, cmd_ready=1, busy=0, cur_rgb=0, all pwm outputs 0.
- Reset mid-fade abandons the fade with no further PWM pulses.
- PWM counter: free-running, PWM_BITS wide, +1 every clock, wraps max->0.
- Each channel has a shadow duty and an active duty.
  - Shadow = cur_rgb channel value.
  - Active loads shadow only in the cycle the counter equals max, so duty changes take effect at period boundaries and never truncate a period.
- pwm_x is registered: pwm_x <= (active_x > cnt).
  - Duty 0: output constantly 0.
  - Duty 2^PWM_BITS-1: high 255 of 256 clocks.
- FSM states:
  - IDLE: cmd_ready=1, busy=0.
  - FADE: cmd_ready=0, busy=1.
- Command accepted when cmd_valid && cmd_ready.
  - cmd_fade=0: cur_rgb <= cmd_rgb next cycle; stay IDLE.
  - cmd_fade=1 and cmd_rgb == cur_rgb: no-op; stay IDLE.
  - cmd_fade=1 otherwise: latch target, clear divider, go FADE.
- In FADE:
  - The divider counts 0..FADE_DIV-1. Each wrap is a fade tick.
  - On a tick, each channel independently moves 1 toward its target (inc if below, dec if above, hold if equal).
  - The tick that makes all three channels equal target returns to IDLE in the same cycle. busy falls the cycle cur_rgb reaches target.
  - Total fade time = max(|target-cur|) over channels × FADE_DIV clocks.
- cmd_valid while in FADE is ignored (not accepted). The requester must hold it until cmd_ready.
- Latency, command to PWM: cur_rgb updates 1 cycle after accept. PWM reflects the new duty from the first period starting after the next counter==max, plus 1 register cycle.
- No arithmetic overflow: steps only move toward target. Divider width is 16 bits.

Optional Feature:
- Macro: RGB_LED_FADER_GAMMA_EN.
- Defined: active duty loads gamma(c) = (c*c + 2^PWM_BITS-1) >> PWM_BITS. Mapping: 0->0, 1->1, 16->1, 128->64, 255->255. Uses one shared multiplier time-sliced across channels during the last 3 clocks before counter==max.
- Undefined: active duty = c directly; no multiplier.
- cur_rgb is ungammaed in both cases.

Decomposition:
- Package rgb_led_pkg:
  - PWM_BITS default constant
  - rgb_t struct {red, green, blue}
  - FSM state enum {IDLE, FADE}
  - gamma function
- Sub-module rgb_pwm_channel: shadow/active duty, compare, registered output. Instantiated 3×, sharing the counter and a period-boundary strobe from the parent.

Test Plan (FADE_DIV=4):
- Reset then release with no command -> all pwm 0 for 1024 clocks; cmd_ready=1; busy=0; cur_rgb=0.
- Jump {255,128,0} -> cur_rgb updates next cycle; from the next period, red high 255/256, green 128/256, blue 0 clocks; no partial period.
- Fade 0 -> {10,3,0} -> busy high exactly 40 clocks; green reaches 3 after 12 clocks then holds; cur_rgb={10,3,0}; cmd_ready returns the same cycle busy falls.
- Fade {10,10,10} -> {8,12,10} -> red decrements while green increments; done after 8 clocks; blue never changes.
- cmd_valid pulsed mid-fade, then held -> first pulse not accepted; held command accepted on the first IDLE cycle. Separately, rst_n asserted mid-fade -> outputs 0 immediately, asynchronously.
- With RGB_LED_FADER_GAMMA_EN, jump to {128,1,255} -> measured duties 64, 1, 255 clocks per period.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared defaults, colour/state types and the gamma curve for rgb_led_fader.
package rgb_led_pkg;
  localparam int PWM_BITS_DEF = 8;
  typedef struct packed {
    logic [PWM_BITS_DEF-1:0] red;
    logic [PWM_BITS_DEF-1:0] green;
    logic [PWM_BITS_DEF-1:0] blue;
  } rgb_t;
  typedef enum logic {IDLE, FADE} state_t;
  // Rounds up so that any non-zero input still lights the LED.
  function automatic logic [15:0] gamma(input logic [15:0] c, input int unsigned bits);
    logic [31:0] p;
    p = 32'(c) * 32'(c) + ((32'd1 << bits) - 32'd1);
    return 16'(p >> bits);
  endfunction
endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one PWM channel; duty is latched only at period ends so no period is truncated.
module rgb_pwm_channel
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                load,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);
  logic [PWM_BITS-1:0] active;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load) active <= duty;
      pwm <= active > cnt;
    end
endmodule

// File: rtl/rgb_led_fader.sv
// rgb_led_fader: RGB colour controller with jump/fade commands and three PWM outputs.
// Optional macro RGB_LED_FADER_GAMMA_EN applies a gamma curve to the PWM duties.
module rgb_led_fader
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3*PWM_BITS-1:0] cmd_rgb,
  input  logic                  cmd_fade,
  output logic                  busy,
  output logic [3*PWM_BITS-1:0] cur_rgb,
  output logic                  pwm_red,
  output logic                  pwm_green,
  output logic                  pwm_blue
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [15:0] DIV_LAST = 16'(FADE_DIV - 1);
  state_t                state;
  logic [PWM_BITS-1:0]   cnt;
  logic [15:0]           div;
  logic [3*PWM_BITS-1:0] tgt, nxt, duty;
  logic [2:0]            pwm_v;
  logic                  period_end;
  assign cmd_ready  = state == IDLE;
  assign busy       = state == FADE;
  assign period_end = cnt == MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt + 1'b1;
  always_comb begin
    nxt = cur_rgb;
    for (int i = 0; i < 3; i++)
      nxt[i*PWM_BITS +: PWM_BITS] =
        cur_rgb[i*PWM_BITS +: PWM_BITS] < tgt[i*PWM_BITS +: PWM_BITS] ? cur_rgb[i*PWM_BITS +: PWM_BITS] + 1'b1 :
        cur_rgb[i*PWM_BITS +: PWM_BITS] > tgt[i*PWM_BITS +: PWM_BITS] ? cur_rgb[i*PWM_BITS +: PWM_BITS] - 1'b1 :
        cur_rgb[i*PWM_BITS +: PWM_BITS];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cur_rgb <= '0;
      tgt     <= '0;
      div     <= '0;
    end else if (state == IDLE) begin
      if (cmd_valid && !cmd_fade) cur_rgb <= cmd_rgb;
      else if (cmd_valid && cmd_rgb != cur_rgb) begin
        tgt   <= cmd_rgb;
        div   <= '0;
        state <= FADE;
      end
    end else if (div == DIV_LAST) begin
      div     <= '0;
      cur_rgb <= nxt;
      if (nxt == tgt) state <= IDLE;
    end else div <= div + 16'd1;
`ifdef RGB_LED_FADER_GAMMA_EN
  // One multiplier serves the three channels in the last three counts before the period end.
  localparam logic [PWM_BITS-1:0] WIN = MAX - PWM_BITS'(3);
  logic [PWM_BITS-1:0] gam [3];
  logic [1:0]          slot;
  logic                in_win;
  assign slot   = 2'(cnt - WIN);
  assign in_win = cnt >= WIN && !period_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gam <= '{default: '0};
    else if (in_win) gam[slot] <= PWM_BITS'(gamma(16'(cur_rgb[slot*PWM_BITS +: PWM_BITS]), PWM_BITS));
  assign duty = {gam[2], gam[1], gam[0]};
`else
  assign duty = cur_rgb;
`endif
  for (genvar i = 0; i < 3; i++) begin : g_ch
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .cnt  (cnt),
      .load (period_end),
      .duty (duty[i*PWM_BITS +: PWM_BITS]),
      .pwm  (pwm_v[i])
    );
  end
  assign pwm_blue  = pwm_v[0];
  assign pwm_green = pwm_v[1];
  assign pwm_red   = pwm_v[2];
endmodule
